btn_repeat: RTL and testbench

Multi-channel push-button conditioner with debounce, press/release edge pulses and typematic auto-repeat. It is the parametrised successor of the single-button delay pulser. Each of N_CH raw button inputs is synchronised and debounced. A debounced press emits one press pulse, then after a hold interval emits repeat pulses at a fixed rate until release. It sits between the board button pins and the menu/counter control logic, which consumes single-cycle strobes only.

---
 rtl/btn_repeat.sv | 129 ++++++++++++
 tb/tb_btn_repeat.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_repeat.sv
// btn_repeat: per-channel button conditioner. Synchronises and debounces each
// raw button, emits press/release strobes and typematic auto-repeat strobes.
module btn_repeat #(
    parameter int N_CH     = 4,
    parameter int DEB_DLY  = 1000000,
    parameter int HOLD_DLY = 50000000,
    parameter int RPT_DLY  = 10000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn,
    input  logic [N_CH-1:0] rpt_en,
    output logic [N_CH-1:0] btn_lvl,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_rpt,
    output logic [N_CH-1:0] btn_rel
);
    localparam int MAX_DLY = (HOLD_DLY > RPT_DLY) ? HOLD_DLY : RPT_DLY;
    localparam int DCNT_W  = $clog2(DEB_DLY + 1);
    localparam int RCNT_W  = $clog2(MAX_DLY + 1);
    localparam logic [DCNT_W-1:0] DEB_LAST  = DCNT_W'(DEB_DLY - 1);
    localparam logic [RCNT_W-1:0] HOLD_LAST = RCNT_W'(HOLD_DLY - 1);
    localparam logic [RCNT_W-1:0] RPT_LAST  = RCNT_W'(RPT_DLY - 1);

    typedef enum logic [1:0] {IDLE, HOLD, RPT} rpt_state_t;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic              sync0_reg;
            logic              sync1_reg;
            logic              lvl_reg;
            logic              press_reg;
            logic              rel_reg;
            logic              rpt_reg;
            logic [DCNT_W-1:0] dcnt_reg;
            logic [RCNT_W-1:0] rcnt_reg;
            rpt_state_t        state_reg;
            logic              deb_done;
            logic              rise_evt;
            logic              fall_evt;

            // The level flip, the edge strobes and the repeat FSM all act on the
            // same edge, so the FSM sees the debounce terminal count directly.
            assign deb_done = (sync1_reg != lvl_reg) && (dcnt_reg == DEB_LAST);
            assign rise_evt = deb_done && sync1_reg;
            assign fall_evt = deb_done && !sync1_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync0_reg <= 1'b0;
                    sync1_reg <= 1'b0;
                    lvl_reg   <= 1'b0;
                    press_reg <= 1'b0;
                    rel_reg   <= 1'b0;
                    rpt_reg   <= 1'b0;
                    dcnt_reg  <= '0;
                    rcnt_reg  <= '0;
                    state_reg <= IDLE;
                end else begin
                    sync0_reg <= btn[gi];
                    sync1_reg <= sync0_reg;
                    press_reg <= 1'b0;
                    rel_reg   <= 1'b0;
                    rpt_reg   <= 1'b0;

                    if (sync1_reg != lvl_reg) begin
                        if (deb_done) begin
                            lvl_reg   <= sync1_reg;
                            dcnt_reg  <= '0;
                            press_reg <= sync1_reg;
                            rel_reg   <= !sync1_reg;
                        end else begin
                            dcnt_reg <= dcnt_reg + 1'b1;
                        end
                    end else begin
                        dcnt_reg <= '0;
                    end

                    // Release overrides any repeat terminal count on the same edge.
                    if (fall_evt) begin
                        state_reg <= IDLE;
                        rcnt_reg  <= '0;
                    end else begin
                        case (state_reg)
                            IDLE: begin
                                if (rise_evt) begin
                                    state_reg <= HOLD;
                                    rcnt_reg  <= '0;
                                end
                            end
                            HOLD: begin
                                if (!rpt_en[gi]) begin
                                    rcnt_reg <= '0;
                                end else if (rcnt_reg == HOLD_LAST) begin
                                    rpt_reg   <= 1'b1;
                                    state_reg <= RPT;
                                    rcnt_reg  <= '0;
                                end else begin
                                    rcnt_reg <= rcnt_reg + 1'b1;
                                end
                            end
                            RPT: begin
                                if (!rpt_en[gi]) begin
                                    state_reg <= HOLD;
                                    rcnt_reg  <= '0;
                                end else if (rcnt_reg == RPT_LAST) begin
                                    rpt_reg  <= 1'b1;
                                    rcnt_reg <= '0;
                                end else begin
                                    rcnt_reg <= rcnt_reg + 1'b1;
                                end
                            end
                            default: begin
                                state_reg <= IDLE;
                                rcnt_reg  <= '0;
                            end
                        endcase
                    end
                end
            end

            assign btn_lvl[gi]   = lvl_reg;
            assign btn_press[gi] = press_reg;
            assign btn_rpt[gi]   = rpt_reg;
            assign btn_rel[gi]   = rel_reg;
        end
    endgenerate
endmodule

// File: tb/tb_btn_repeat.sv
// Bench for btn_repeat: table of press/hold/release rows plus hand-written
// corner sequences, all checked cycle by cycle against a timed event scoreboard.
module tb_btn_repeat;
    localparam int N_CH = 2;
    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int RPT  = 3;
    localparam int LAT  = DEB + 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N_CH-1:0] btn = '0;
    logic [N_CH-1:0] rpt_en = '0;
    logic [N_CH-1:0] btn_lvl;
    logic [N_CH-1:0] btn_press;
    logic [N_CH-1:0] btn_rpt;
    logic [N_CH-1:0] btn_rel;

    btn_repeat #(
        .N_CH    (N_CH),
        .DEB_DLY (DEB),
        .HOLD_DLY(HOLD),
        .RPT_DLY (RPT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .rpt_en   (rpt_en),
        .btn_lvl  (btn_lvl),
        .btn_press(btn_press),
        .btn_rpt  (btn_rpt),
        .btn_rel  (btn_rel)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_PRESS, EV_RPT, EV_REL} ev_kind_t;
    typedef struct {
        int       cyc;
        int       ch;
        ev_kind_t kind;
    } ev_t;

    typedef struct {
        int ch;
        bit rpt;
        int hold;
        int exp_press;
        int exp_rpt;
    } row_t;

    ev_t             sb_q[$];
    int              ecount = 0;
    int              tests  = 0;
    int              fails  = 0;
    logic [N_CH-1:0] lvl_exp = '0;
    logic [N_CH-1:0] ep, er, el;
    int              press_cnt[N_CH];
    int              rpt_cnt[N_CH];
    int              rel_cnt[N_CH];
    row_t            rows[7];
    int              n, m, p0, r0, l0, r1;

    always @(posedge clk) ecount <= ecount + 1;

    task automatic check(input string name, input logic [N_CH-1:0] act, input logic [N_CH-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %b want %b", name, ecount, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %0d want %0d", name, ecount, act, exp);
        end
    endtask

    task automatic push(input int cyc, input int ch, input ev_kind_t kind);
        ev_t e;
        e.cyc  = cyc;
        e.ch   = ch;
        e.kind = kind;
        sb_q.push_back(e);
    endtask

    // Repeats fall every RPT cycles from the first one, strictly before release.
    task automatic push_rpts(input int ch, input int first, input int rel);
        for (int t = first; t < rel; t += RPT) push(t, ch, EV_RPT);
    endtask

    task automatic wait_to(input int e);
        while (ecount < e) @(negedge clk);
    endtask

    initial begin
        fork
            begin : monitor
                forever begin
                    @(posedge clk);
                    #2;
                    ep = '0;
                    er = '0;
                    el = '0;
                    for (int i = sb_q.size() - 1; i >= 0; i--) begin
                        if (sb_q[i].cyc == ecount) begin
                            case (sb_q[i].kind)
                                EV_PRESS: ep[sb_q[i].ch] = 1'b1;
                                EV_RPT:   er[sb_q[i].ch] = 1'b1;
                                default:  el[sb_q[i].ch] = 1'b1;
                            endcase
                            sb_q.delete(i);
                        end else if (sb_q[i].cyc < ecount) begin
                            tests++;
                            fails++;
                            $display("FAIL stale_event @cycle %0d: got none want kind %0d ch%0d at %0d",
                                     ecount, sb_q[i].kind, sb_q[i].ch, sb_q[i].cyc);
                            sb_q.delete(i);
                        end
                    end
                    if (rst) lvl_exp = '0;
                    else     lvl_exp = (lvl_exp | ep) & ~el;
                    check("btn_lvl", btn_lvl, lvl_exp);
                    check("btn_press", btn_press, ep);
                    check("btn_rpt", btn_rpt, er);
                    check("btn_rel", btn_rel, el);
                    for (int c = 0; c < N_CH; c++) begin
                        press_cnt[c] += int'(btn_press[c]);
                        rpt_cnt[c]   += int'(btn_rpt[c]);
                        rel_cnt[c]   += int'(btn_rel[c]);
                    end
                end
            end
            begin : stimulus
                rows[0] = '{0, 1'b0, 12, 1, 0};  // clean press, no repeat
                rows[1] = '{0, 1'b1, 30, 1, 7};  // held 30 past press
                rows[2] = '{1, 1'b1, 16, 1, 2};
                rows[3] = '{1, 1'b1, 10, 1, 0};  // release lands on first terminal count
                rows[4] = '{0, 1'b1, 19, 1, 3};  // release lands on a repeat terminal count
                rows[5] = '{1, 1'b1, 4,  1, 0};  // shortest press that survives debounce
                rows[6] = '{0, 1'b1, 3,  0, 0};  // glitch one cycle too short

                repeat (3) @(negedge clk);
                rst = 1'b0;
                repeat (2) @(negedge clk);

                for (int i = 0; i < 7; i++) begin
                    n  = ecount;
                    p0 = press_cnt[rows[i].ch];
                    r0 = rpt_cnt[rows[i].ch];
                    l0 = rel_cnt[rows[i].ch];
                    btn[rows[i].ch]    = 1'b1;
                    rpt_en[rows[i].ch] = rows[i].rpt;
                    if (rows[i].exp_press != 0) begin
                        push(n + LAT, rows[i].ch, EV_PRESS);
                        push(n + rows[i].hold + LAT, rows[i].ch, EV_REL);
                        if (rows[i].rpt) push_rpts(rows[i].ch, n + LAT + HOLD, n + rows[i].hold + LAT);
                    end
                    wait_to(n + rows[i].hold);
                    btn[rows[i].ch] = 1'b0;
                    wait_to(n + rows[i].hold + LAT + 6);
                    rpt_en = '0;
                    check_int("row_press", press_cnt[rows[i].ch] - p0, rows[i].exp_press);
                    check_int("row_rpt", rpt_cnt[rows[i].ch] - r0, rows[i].exp_rpt);
                    check_int("row_rel", rel_cnt[rows[i].ch] - l0, rows[i].exp_press);
                    $display("[TB] row %0d: ch%0d rpt_en=%0d hold=%0d presses=%0d repeats=%0d",
                             i, rows[i].ch, rows[i].rpt, rows[i].hold,
                             press_cnt[rows[i].ch] - p0, rpt_cnt[rows[i].ch] - r0);
                end

                // Bounce: 3 cycles high, 3 low, five times.
                p0 = press_cnt[0];
                l0 = rel_cnt[0];
                for (int k = 0; k < 5; k++) begin
                    btn[0] = 1'b1;
                    repeat (3) @(negedge clk);
                    btn[0] = 1'b0;
                    repeat (3) @(negedge clk);
                end
                repeat (8) @(negedge clk);
                check_int("bounce_press", press_cnt[0] - p0, 0);
                check_int("bounce_rel", rel_cnt[0] - l0, 0);
                $display("[TB] bounce: presses=%0d releases=%0d", press_cnt[0] - p0, rel_cnt[0] - l0);

                // Repeat enable raised late on ch1 restarts the full hold interval.
                n  = ecount;
                r0 = rpt_cnt[1];
                btn[1] = 1'b1;
                push(n + LAT, 1, EV_PRESS);
                wait_to(n + LAT + 20);
                m = ecount;
                rpt_en[1] = 1'b1;
                push_rpts(1, m + HOLD, m + 11 + LAT);
                push(m + 11 + LAT, 1, EV_REL);
                wait_to(m + 11);
                btn[1] = 1'b0;
                wait_to(m + 11 + LAT + 4);
                rpt_en = '0;
                check_int("rpt_en_late_rpts", rpt_cnt[1] - r0, 3);
                $display("[TB] rpt_en late: repeats=%0d", rpt_cnt[1] - r0);

                // Reset while ch0 is repeating with the button still held.
                n  = ecount;
                p0 = press_cnt[0];
                btn[0]    = 1'b1;
                rpt_en[0] = 1'b1;
                push(n + LAT, 0, EV_PRESS);
                push_rpts(0, n + LAT + HOLD, n + 20);
                wait_to(n + 20);
                rst = 1'b1;
                sb_q.delete();
                wait_to(n + 21);
                rst = 1'b0;
                push(n + 21 + LAT, 0, EV_PRESS);
                push_rpts(0, n + 21 + LAT + HOLD, n + 41 + LAT);
                push(n + 41 + LAT, 0, EV_REL);
                wait_to(n + 41);
                btn[0] = 1'b0;
                wait_to(n + 41 + LAT + 4);
                rpt_en = '0;
                check_int("reset_mid_press", press_cnt[0] - p0, 2);
                $display("[TB] reset mid-repeat: presses=%0d", press_cnt[0] - p0);

                // ch0 release on a repeat terminal count while ch1 is pressed.
                n  = ecount;
                r0 = rpt_cnt[0];
                r1 = rpt_cnt[1];
                p0 = press_cnt[1];
                btn[0]    = 1'b1;
                rpt_en[0] = 1'b1;
                push(n + LAT, 0, EV_PRESS);
                push_rpts(0, n + LAT + HOLD, n + 19 + LAT);
                push(n + 19 + LAT, 0, EV_REL);
                wait_to(n + 19);
                btn[0] = 1'b0;
                btn[1] = 1'b1;
                push(n + 19 + LAT, 1, EV_PRESS);
                wait_to(n + 35);
                btn[1] = 1'b0;
                push(n + 35 + LAT, 1, EV_REL);
                wait_to(n + 35 + LAT + 4);
                rpt_en = '0;
                check_int("indep_ch0_rpts", rpt_cnt[0] - r0, 3);
                check_int("indep_ch1_rpts", rpt_cnt[1] - r1, 0);
                check_int("indep_ch1_press", press_cnt[1] - p0, 1);
                $display("[TB] independence: ch0 repeats=%0d ch1 presses=%0d",
                         rpt_cnt[0] - r0, press_cnt[1] - p0);

                check_int("scoreboard_empty", sb_q.size(), 0);
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $finish;
            end
        join_any
    end
endmodule
